// File: rtl/mux_pkg.sv
// Shared definitions for the registered N:1 scanning multiplexer.
// Optional feature macro used across this slice: MUX_SCAN_MASK_EN
// (adds the ch_mask port and masked auto-scan).
package mux_pkg;

  // Selection mode encoding driven on the mode input.
  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_AUTO   = 1'b1
  } scanMode_e;

  // Ceiling log2 for toolflows without $clog2; clog2(1) returns 0.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result++;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/mux_scan_nx1_scan_ptr.sv
// Channel scanner: owns the scan pointer, the dwell counter and the
// next-channel priority search used by auto-scan mode.
// Optional feature macro: MUX_SCAN_MASK_EN (the mask input is always
// present here; the top ties it to all ones when the feature is off).
module scan_ptr
  import mux_pkg::*;
#(
  parameter  int NCH   = 4,
  parameter  int DWELL = 1,
  localparam int SELW  = clog2(NCH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            mode,
  input  logic [SELW-1:0] sel,
  input  logic [NCH-1:0]  chMask,
  output logic [SELW-1:0] chPtr
);

  localparam int              CNTW      = (DWELL > 1) ? clog2(DWELL) : 1;
  localparam logic [CNTW-1:0] DWELL_END = CNTW'(DWELL - 1);

  logic [CNTW-1:0] dwellCnt;
  logic [SELW-1:0] nextCh;
  logic [SELW-1:0] candCh;
  logic            anyChannel;

  // Find the first enabled channel above chPtr, wrapping; the offset of NCH
  // wraps back onto chPtr itself so the current channel is the last candidate.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    nextCh     = chPtr;
    candCh     = chPtr;
    anyChannel = |chMask;
    for (int i = NCH; i >= 1; i--) begin
      candCh = chPtr + SELW'(i);
      if (chMask[candCh]) nextCh = candCh;
    end
  end

  // Pointer and dwell state: manual mode parks on sel, auto mode steps after
  // each full dwell; en low or an empty mask freezes both exactly.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst_n) begin
      chPtr    <= '0;
      dwellCnt <= '0;
    end else if (en && anyChannel) begin
      if (mode == MODE_MANUAL) begin
        chPtr    <= sel;
        dwellCnt <= '0;
      end else if (dwellCnt == DWELL_END) begin
        chPtr    <= nextCh;
        dwellCnt <= '0;
      end else begin
        dwellCnt <= dwellCnt + CNTW'(1);
      end
    end
  end

endmodule

// File: rtl/mux_scan_nx1.sv
// Registered N:1 multiplexer with manual select and auto channel scan.
// Optional feature macro: MUX_SCAN_MASK_EN (adds ch_mask; masked channels
// are skipped by the scanner and never produce a valid output).
module mux_scan_nx1
  import mux_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int NCH   = 4,
  parameter  int DWELL = 1,
  localparam int SELW  = clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] din,
  input  logic [SELW-1:0]      sel,
  input  logic                 mode,
  input  logic                 en,
`ifdef MUX_SCAN_MASK_EN
  input  logic [NCH-1:0]       ch_mask,
`endif
  output logic [WIDTH-1:0]     out,
  output logic [SELW-1:0]      out_ch,
  output logic                 out_valid
);

  logic [NCH-1:0]   chMaskEff;
  logic [SELW-1:0]  chPtr;
  logic [SELW-1:0]  curCh;
  logic [WIDTH-1:0] curData;
  logic             curEnabled;

`ifdef MUX_SCAN_MASK_EN
  assign chMaskEff = ch_mask;
`else
  // Without the mask feature every channel takes part in the scan.
  assign chMaskEff = '1;
`endif

  scan_ptr #(
    .NCH   (NCH),
    .DWELL (DWELL)
  ) u_scan_ptr (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .mode   (mode),
    .sel    (sel),
    .chMask (chMaskEff),
    .chPtr  (chPtr)
  );

  // Channel for this cycle: sel wins at once in manual mode, otherwise the
  // scanner position; a masked channel yields no output.
  always_comb begin
    curCh      = (mode == MODE_AUTO) ? chPtr : sel;
    curData    = din[curCh*WIDTH +: WIDTH];
    curEnabled = chMaskEff[curCh];
  end

  // Output register: one-cycle latency, valid only on a sampling edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out       <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
    end else if (en && curEnabled) begin
      out       <= curData;
      out_ch    <= curCh;
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_scan_nx1.sv
// Directed self-checking bench for mux_scan_nx1 (WIDTH=8, NCH=4, DWELL=2).
// Mask scenarios are built only when MUX_SCAN_MASK_EN is defined.
module tb_mux_scan_nx1;

  localparam int WIDTH = 8;
  localparam int NCH   = 4;
  localparam int DWELL = 2;

  logic             clk;
  logic             rst_n;
  logic [31:0]      din;
  logic [1:0]       sel;
  logic             mode;
  logic             en;
  logic [NCH-1:0]   ch_mask;
  logic [WIDTH-1:0] out;
  logic [1:0]       out_ch;
  logic             out_valid;

  int checks;
  int errors;

  mux_scan_nx1 #(
    .WIDTH (WIDTH),
    .NCH   (NCH),
    .DWELL (DWELL)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .sel       (sel),
    .mode      (mode),
    .en        (en),
`ifdef MUX_SCAN_MASK_EN
    .ch_mask   (ch_mask),
`endif
    .out       (out),
    .out_ch    (out_ch),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; inputs are driven and outputs sampled 1 time
  // unit after it, well away from the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    din     = {8'h44, 8'h33, 8'h22, 8'h11};
    sel     = 2'd2;
    mode    = 1'b0;
    en      = 1'b1;
    ch_mask = 4'b1111;
    step();
    step();
    checks++;
    if (out !== 8'h00 || out_ch !== 2'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset: out=%h out_ch=%0d valid=%b, required out=00 out_ch=0 valid=0",
               out, out_ch, out_valid);
    end
  endtask

  task automatic test_manual();
    logic [1:0] sels [3];
    logic [7:0] exp  [3];
    sels = '{2'd2, 2'd0, 2'd3};
    exp  = '{8'h33, 8'h11, 8'h44};
    rst_n = 1'b1;
    mode  = 1'b0;
    en    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sel = sels[i];
      step();
      checks++;
      if (out !== exp[i] || out_ch !== sels[i] || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL manual[%0d]: out=%h out_ch=%0d valid=%b, required out=%h out_ch=%0d valid=1",
                 i, out, out_ch, out_valid, exp[i], sels[i]);
      end
    end
    // New data on channel 2 must appear one edge after it is sampled.
    din = {8'h44, 8'hA5, 8'h22, 8'h11};
    sel = 2'd2;
    step();
    checks++;
    if (out !== 8'hA5 || out_ch !== 2'd2) begin
      errors++;
      $display("FAIL manual_newdata: out=%h out_ch=%0d, required out=a5 out_ch=2", out, out_ch);
    end
    din = {8'h44, 8'h33, 8'h22, 8'h11};
  endtask

  task automatic test_auto_wrap();
    logic [1:0] expCh [9];
    logic [7:0] expD  [4];
    expCh = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
    expD  = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_reset();
    mode = 1'b1;
    en   = 1'b1;
    sel  = 2'd2;  // ignored in auto mode
    for (int i = 0; i < 9; i++) begin
      step();
      checks++;
      if (out_ch !== expCh[i] || out !== expD[expCh[i]] || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL auto_wrap[%0d]: out_ch=%0d out=%h valid=%b, required out_ch=%0d out=%h valid=1",
                 i, out_ch, out, out_valid, expCh[i], expD[expCh[i]]);
      end
    end
  endtask

  task automatic test_stall();
    logic [1:0] expCh [3];
    do_reset();
    mode = 1'b1;
    en   = 1'b1;
    step();  // ch0
    step();  // ch0
    step();  // ch1, first of its two dwell cycles
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0 || out_ch !== 2'd1 || out !== 8'h22) begin
        errors++;
        $display("FAIL stall[%0d]: valid=%b out_ch=%0d out=%h, required valid=0 out_ch=1 out=22",
                 i, out_valid, out_ch, out);
      end
    end
    en    = 1'b1;
    expCh = '{2'd1, 2'd2, 2'd2};
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_ch !== expCh[i]) begin
        errors++;
        $display("FAIL resume[%0d]: valid=%b out_ch=%0d, required valid=1 out_ch=%0d",
                 i, out_valid, out_ch, expCh[i]);
      end
    end
  endtask

  task automatic test_manual_to_auto();
    logic [1:0] expCh [3];
    do_reset();
    en   = 1'b1;
    mode = 1'b0;
    sel  = 2'd3;
    step();
    mode  = 1'b1;
    sel   = 2'd1;  // must not influence the scan
    expCh = '{2'd3, 2'd3, 2'd0};
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (out_ch !== expCh[i] || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL man2auto[%0d]: out_ch=%0d valid=%b, required out_ch=%0d valid=1",
                 i, out_ch, out_valid, expCh[i]);
      end
    end
    // Auto back to manual takes effect on the very next edge.
    mode = 1'b0;
    sel  = 2'd2;
    step();
    checks++;
    if (out_ch !== 2'd2 || out !== 8'h33) begin
      errors++;
      $display("FAIL auto2man: out_ch=%0d out=%h, required out_ch=2 out=33", out_ch, out);
    end
  endtask

  task automatic test_reset_mid_scan();
    logic [1:0] expCh [3];
    do_reset();
    mode = 1'b1;
    en   = 1'b1;
    for (int i = 0; i < 5; i++) step();  // 0,0,1,1,2
    checks++;
    if (out_ch !== 2'd2) begin
      errors++;
      $display("FAIL midscan_pre: out_ch=%0d, required 2", out_ch);
    end
    rst_n = 1'b0;
    step();
    checks++;
    if (out !== 8'h00 || out_ch !== 2'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midscan_reset: out=%h out_ch=%0d valid=%b, required 00/0/0",
               out, out_ch, out_valid);
    end
    rst_n = 1'b1;
    expCh = '{2'd0, 2'd0, 2'd1};
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (out_ch !== expCh[i] || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL midscan_after[%0d]: out_ch=%0d valid=%b, required out_ch=%0d valid=1",
                 i, out_ch, out_valid, expCh[i]);
      end
    end
  endtask

`ifdef MUX_SCAN_MASK_EN
  task automatic test_mask();
    logic       expV  [7];
    logic [1:0] expCh [7];
    ch_mask = 4'b1010;
    do_reset();
    mode = 1'b1;
    en   = 1'b1;
    // Channel 0 is masked but still dwells for two silent cycles.
    expV  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    expCh = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd3, 2'd3, 2'd1};
    for (int i = 0; i < 7; i++) begin
      step();
      checks++;
      if (out_valid !== expV[i] || out_ch !== expCh[i]) begin
        errors++;
        $display("FAIL mask1010[%0d]: valid=%b out_ch=%0d, required valid=%b out_ch=%0d",
                 i, out_valid, out_ch, expV[i], expCh[i]);
      end
    end
    ch_mask = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL mask0[%0d]: valid=%b, required 0", i, out_valid);
      end
    end
    ch_mask = 4'b1111;
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_manual();
    test_auto_wrap();
    test_stall();
    test_manual_to_auto();
    test_reset_mid_scan();
`ifdef MUX_SCAN_MASK_EN
    test_mask();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
